multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle MIPS core: replaces the single-cycle `Control` decoder with a Moore/Mealy FSM that steps the shared ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and writeback. It sits between the instruction register (opcode), the ALU `Zero` flag and a variable-latency memory with a ready handshake. It drives every datapath enable and mux select, and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 59 +++++
 rtl/mc_retire_counter.sv | 23 ++
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, opcodes and datapath select encodings for the multi-cycle controller.
// The STEPWAIT state only exists when MC_DEBUG_STEP_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExec     = 4'd6,
        StAluWb    = 4'd7,
        StBeq      = 4'd8,
        StAddiEx   = 4'd9,
        StAddiWb   = 4'd10,
        StJump     = 4'd11,
        StHalt     = 4'd12
`ifdef MC_DEBUG_STEP_EN
        ,
        StStepWait = 4'd13
`endif
    } mcState_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBBranch = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // First execution state for an opcode; anything unknown parks in HALT.
    function automatic mcState_e decodeTarget(input logic [5:0] op);
        mcState_e st;
        unique case (op)
            OpLw, OpSw: st = StMemAdr;
            OpRType:    st = StExec;
            OpBeq:      st = StBeq;
            OpAddi:     st = StAddiEx;
            OpJ:        st = StJump;
            default:    st = StHalt;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module mc_retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Inc,
    output logic [CNT_W-1:0] Count
);

    logic [CNT_W-1:0] countQ;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            countQ <= '0;
        end else if (Inc) begin
            countQ <= countQ + CNT_W'(1);
        end
    end

    assign Count = countQ;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: drives datapath enables/selects and counts retirements.
// Optional single-step debug support is enabled with MC_DEBUG_STEP_EN.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCEn,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             Retired,
    output logic [CNT_W-1:0] RetireCount,
    output logic             IllegalOp
`ifdef MC_DEBUG_STEP_EN
    ,
    input  logic             DbgHalt,
    input  logic             DbgStep,
    output logic             DbgHalted
`endif
);

    mcState_e stateQ, stateD;
    mcState_e fetchNext;

    logic       memRead, memWrite, iorD, irWrite, pcEn, regWrite;
    logic       regDst, memtoReg, aluSrcA, retired, dbgHalted;
    logic [1:0] aluSrcB, aluOp, pcSrc;

`ifdef MC_DEBUG_STEP_EN
    // Halt requests are only honoured at an instruction boundary.
    assign fetchNext = DbgHalt ? StStepWait : StFetch;
`else
    assign fetchNext = StFetch;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iorD      = 1'b0;
        irWrite   = 1'b0;
        pcEn      = 1'b0;
        regWrite  = 1'b0;
        regDst    = 1'b0;
        memtoReg  = 1'b0;
        aluSrcA   = 1'b0;
        retired   = 1'b0;
        dbgHalted = 1'b0;
        aluSrcB   = SrcBReg;
        aluOp     = AluOpAdd;
        pcSrc     = PcSrcAlu;

        unique case (stateQ)
            StFetch: begin
                memRead = 1'b1;
                aluSrcB = SrcBFour;
                aluOp   = AluOpAdd;
                pcSrc   = PcSrcAlu;
                irWrite = MemReady;
                pcEn    = MemReady;
                if (MemReady) stateD = StDecode;
            end
            StDecode: begin
                aluSrcB = SrcBBranch;
                stateD  = decodeTarget(Op);
            end
            StMemAdr: begin
                aluSrcA = 1'b1;
                aluSrcB = SrcBImm;
                stateD  = (Op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (MemReady) stateD = StMemWb;
            end
            StMemWb: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
                retired  = 1'b1;
                stateD   = fetchNext;
            end
            StMemWr: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (MemReady) begin
                    retired = 1'b1;
                    stateD  = fetchNext;
                end
            end
            StExec: begin
                aluSrcA = 1'b1;
                aluSrcB = SrcBReg;
                aluOp   = AluOpFunct;
                stateD  = StAluWb;
            end
            StAluWb: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                retired  = 1'b1;
                stateD   = fetchNext;
            end
            StBeq: begin
                aluSrcA = 1'b1;
                aluSrcB = SrcBReg;
                aluOp   = AluOpSub;
                pcSrc   = PcSrcAluOut;
                pcEn    = Zero;
                retired = 1'b1;
                stateD  = fetchNext;
            end
            StAddiEx: begin
                aluSrcA = 1'b1;
                aluSrcB = SrcBImm;
                stateD  = StAddiWb;
            end
            StAddiWb: begin
                regWrite = 1'b1;
                retired  = 1'b1;
                stateD   = fetchNext;
            end
            StJump: begin
                pcSrc   = PcSrcJump;
                pcEn    = 1'b1;
                retired = 1'b1;
                stateD  = fetchNext;
            end
            StHalt: begin
                stateD = StHalt;
            end
`ifdef MC_DEBUG_STEP_EN
            StStepWait: begin
                dbgHalted = 1'b1;
                if (!DbgHalt || DbgStep) stateD = StFetch;
            end
`endif
            default: stateD = StFetch;
        endcase
    end

    // Everything is held quiet while reset is asserted, even though the state reads FETCH.
    assign MemRead   = Reset & memRead;
    assign MemWrite  = Reset & memWrite;
    assign IorD      = Reset & iorD;
    assign IRWrite   = Reset & irWrite;
    assign PCEn      = Reset & pcEn;
    assign RegWrite  = Reset & regWrite;
    assign RegDst    = Reset & regDst;
    assign MemtoReg  = Reset & memtoReg;
    assign ALUSrcA   = Reset & aluSrcA;
    assign ALUSrcB   = {2{Reset}} & aluSrcB;
    assign ALUOp     = {2{Reset}} & aluOp;
    assign PCSrc     = {2{Reset}} & pcSrc;
    assign Retired   = Reset & retired;
    assign IllegalOp = Reset & (stateQ == StHalt);

`ifdef MC_DEBUG_STEP_EN
    assign DbgHalted = Reset & dbgHalted;
`else
    logic unusedDbg;
    assign unusedDbg = dbgHalted;
`endif

    mc_retire_counter #(
        .CNT_W (CNT_W)
    ) uRetireCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (retired),
        .Count (RetireCount)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table, corner sequences and
// randomized instruction stream checked against an instruction-level reference model.
module tb_multicycle_control;

    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [5:0]       Op = 6'd0;
    logic             Zero = 1'b0;
    logic             MemReady = 1'b0;
    logic             MemRead, MemWrite, IorD, IRWrite, PCEn, RegWrite;
    logic             RegDst, MemtoReg, ALUSrcA, Retired, IllegalOp;
    logic [1:0]       ALUSrcB, ALUOp, PCSrc;
    logic [CNT_W-1:0] RetireCount;
`ifdef MC_DEBUG_STEP_EN
    logic             DbgHalt = 1'b0;
    logic             DbgStep = 1'b0;
    logic             DbgHalted;
`endif

    multicycle_control #(
        .CNT_W (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Op          (Op),
        .Zero        (Zero),
        .MemReady    (MemReady),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCEn        (PCEn),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSrc       (PCSrc),
        .Retired     (Retired),
        .RetireCount (RetireCount),
        .IllegalOp   (IllegalOp)
`ifdef MC_DEBUG_STEP_EN
        ,
        .DbgHalt     (DbgHalt),
        .DbgStep     (DbgStep),
        .DbgHalted   (DbgHalted)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       irWrite;
        logic       pcEn;
        logic       regWrite;
        logic       regDst;
        logic       memtoReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       retired;
        logic       illegalOp;
    } outs_t;

    typedef enum {SF, SD, SMA, SMR, SMWB, SMW, SEX, SAWB, SBEQ, SAE, SIWB, SJ, SH} st_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    outs_t act;
    assign act = {MemRead, MemWrite, IorD, IRWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, Retired, IllegalOp};

    int checks = 0;
    int failures = 0;
    int modelCount = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, got, want);
        end
    endtask

    // Outputs each state must show, straight from the state table.
    function automatic outs_t specOut(input st_t st, input logic rdy, input logic z);
        outs_t o = '0;
        case (st)
            SF:   begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcEn = rdy; end
            SD:   o.aluSrcB = 2'b11;
            SMA:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            SMR:  begin o.memRead = 1; o.iorD = 1; end
            SMWB: begin o.memtoReg = 1; o.regWrite = 1; o.retired = 1; end
            SMW:  begin o.memWrite = 1; o.iorD = 1; o.retired = rdy; end
            SEX:  begin o.aluSrcA = 1; o.aluOp = 2'b10; end
            SAWB: begin o.regDst = 1; o.regWrite = 1; o.retired = 1; end
            SBEQ: begin
                o.aluSrcA = 1; o.aluOp = 2'b01; o.pcSrc = 2'b01; o.pcEn = z; o.retired = 1;
            end
            SAE:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            SIWB: begin o.regWrite = 1; o.retired = 1; end
            SJ:   begin o.pcSrc = 2'b10; o.pcEn = 1; o.retired = 1; end
            SH:   o.illegalOp = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic vec_t mkVec(input logic [5:0] op, input logic z, input logic rdy,
                                   input st_t st);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.exp = specOut(st, rdy, z);
        return v;
    endfunction

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic applyVec(input string name, input vec_t v);
        Op = v.op; Zero = v.z; MemReady = v.rdy;
        #1;
        chk(name, act, v.exp);
        @(negedge Clk);
    endtask

    // Instruction-level model: cycles and strobe totals for one instruction.
    task automatic runInstr(input logic [5:0] op, input logic z, input int fw, input int dw);
        int cyc = 0, rw = 0, mwc = 0, mrc = 0, pce = 0;
        int wleft = fw;
        bit done = 0;
        int expCyc, expRw, expMw, expMr, expPc;
        Op = op; Zero = z;
        while (!done && cyc < 60) begin
            if (MemRead || MemWrite) begin
                if (wleft > 0) begin MemReady = 0; wleft--; end
                else MemReady = 1;
            end else begin
                MemReady = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            rw += int'(RegWrite); mwc += int'(MemWrite); mrc += int'(MemRead);
            pce += int'(PCEn);
            if (MemReady && (MemRead || MemWrite)) wleft = dw;
            if (Retired) done = 1;
            @(negedge Clk);
        end
        chk("instr_completes", 32'(done), 32'd1);
        case (op)
            LW:      expCyc = 5 + fw + dw;
            SW:      expCyc = 4 + fw + dw;
            R, ADDI: expCyc = 4 + fw;
            default: expCyc = 3 + fw;
        endcase
        expRw = (op == R || op == LW || op == ADDI) ? 1 : 0;
        expMw = (op == SW) ? dw + 1 : 0;
        expMr = fw + 1 + ((op == LW) ? dw + 1 : 0);
        expPc = 1 + ((op == J) ? 1 : 0) + ((op == BEQ && z) ? 1 : 0);
        modelCount = (modelCount + 1) % (1 << CNT_W);
        chk($sformatf("cycles op=%0h", op), cyc, expCyc);
        chk($sformatf("regwrite op=%0h", op), rw, expRw);
        chk($sformatf("memwrite op=%0h", op), mwc, expMw);
        chk($sformatf("memread op=%0h", op), mrc, expMr);
        chk($sformatf("pcen op=%0h", op), pce, expPc);
        chk("retire_count", 32'(RetireCount), modelCount);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [5:0] ops [6];
        ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = ADDI; ops[5] = J;

        // R-type, then lw with three MEMRD waits, beq taken/not, j, addi, sw with fetch waits.
        vecs.push_back(mkVec(R, 0, 1, SF));   vecs.push_back(mkVec(R, 0, 1, SD));
        vecs.push_back(mkVec(R, 0, 1, SEX));  vecs.push_back(mkVec(R, 0, 1, SAWB));
        vecs.push_back(mkVec(LW, 0, 1, SF));  vecs.push_back(mkVec(LW, 0, 1, SD));
        vecs.push_back(mkVec(LW, 0, 1, SMA));
        vecs.push_back(mkVec(LW, 0, 0, SMR)); vecs.push_back(mkVec(LW, 0, 0, SMR));
        vecs.push_back(mkVec(LW, 0, 0, SMR)); vecs.push_back(mkVec(LW, 0, 1, SMR));
        vecs.push_back(mkVec(LW, 0, 1, SMWB));
        vecs.push_back(mkVec(BEQ, 1, 1, SF)); vecs.push_back(mkVec(BEQ, 1, 1, SD));
        vecs.push_back(mkVec(BEQ, 1, 1, SBEQ));
        vecs.push_back(mkVec(BEQ, 0, 1, SF)); vecs.push_back(mkVec(BEQ, 0, 1, SD));
        vecs.push_back(mkVec(BEQ, 0, 1, SBEQ));
        vecs.push_back(mkVec(J, 0, 1, SF));   vecs.push_back(mkVec(J, 0, 1, SD));
        vecs.push_back(mkVec(J, 0, 1, SJ));
        vecs.push_back(mkVec(ADDI, 0, 1, SF)); vecs.push_back(mkVec(ADDI, 0, 1, SD));
        vecs.push_back(mkVec(ADDI, 0, 1, SAE)); vecs.push_back(mkVec(ADDI, 0, 1, SIWB));
        vecs.push_back(mkVec(SW, 0, 0, SF));  vecs.push_back(mkVec(SW, 0, 0, SF));
        vecs.push_back(mkVec(SW, 0, 1, SF));  vecs.push_back(mkVec(SW, 0, 1, SD));
        vecs.push_back(mkVec(SW, 0, 1, SMA)); vecs.push_back(mkVec(SW, 0, 1, SMW));

        // Reset held: outputs quiet even with MemReady high.
        MemReady = 1;
        @(negedge Clk); @(negedge Clk);
        #1;
        chk("reset_outs", act, 0);
        chk("reset_count", 32'(RetireCount), 0);
        @(negedge Clk);
        Reset = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 4) chk("retire_after_rtype", 32'(RetireCount), 1);
            applyVec($sformatf("vec%0d", i), vecs[i]);
        end
        chk("retire_after_table", 32'(RetireCount), 7);

        // Illegal opcode parks in HALT.
        applyVec("halt_fetch", mkVec(BAD, 0, 1, SF));
        applyVec("halt_decode", mkVec(BAD, 0, 1, SD));
        for (int i = 0; i < 10; i++) begin
            applyVec($sformatf("halt%0d", i), mkVec(BAD, 0, 1'($urandom_range(0, 1)), SH));
        end
        Reset = 0;
        #1;
        chk("halt_reset_outs", act, 0);
        chk("halt_reset_count", 32'(RetireCount), 0);
        @(negedge Clk);
        Reset = 1;

        // Reset during a MEMWR wait drops the write at once.
        applyVec("rs_r_f", mkVec(R, 0, 1, SF));   applyVec("rs_r_d", mkVec(R, 0, 1, SD));
        applyVec("rs_r_ex", mkVec(R, 0, 1, SEX)); applyVec("rs_r_wb", mkVec(R, 0, 1, SAWB));
        applyVec("rs_sw_f", mkVec(SW, 0, 1, SF)); applyVec("rs_sw_d", mkVec(SW, 0, 1, SD));
        applyVec("rs_sw_ma", mkVec(SW, 0, 1, SMA));
        applyVec("rs_sw_wait", mkVec(SW, 0, 0, SMW));
        chk("rs_count_before", 32'(RetireCount), 1);
        #2;
        MemReady = 1;
        Reset = 0;
        #1;
        chk("rs_memwrite_drop", 32'(MemWrite), 0);
        chk("rs_count_cleared", 32'(RetireCount), 0);
        @(negedge Clk);
        Reset = 1;
        applyVec("rs_release_fetch", mkVec(SW, 0, 0, SF));
        chk("rs_count_after", 32'(RetireCount), 0);

        // Randomized instruction stream; counter wraps at 2^CNT_W.
        modelCount = 0;
        for (int n = 0; n < 280; n++) begin
            runInstr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef MC_DEBUG_STEP_EN
        begin
            int total = 0;
            DbgHalt = 1;
            runInstr(R, 0, 0, 0);
            for (int s = 0; s < 2; s++) begin
                int rc = 0;
                bit halted = 0;
                for (int c = 0; c < 3; c++) begin
                    MemReady = 1'($urandom_range(0, 1));
                    #1;
                    chk("dbg_halted", 32'(DbgHalted), 1);
                    chk("dbg_no_request", 32'(MemRead | MemWrite), 0);
                    @(negedge Clk);
                end
                Op = ADDI; MemReady = 1; DbgStep = 1;
                @(negedge Clk);
                DbgStep = 0;
                for (int c = 0; c < 20 && !halted; c++) begin
                    #1;
                    if (DbgHalted) halted = 1;
                    else begin
                        rc += int'(Retired);
                        @(negedge Clk);
                    end
                end
                chk("dbg_step_returns", 32'(halted), 1);
                total += rc;
                @(negedge Clk);
            end
            chk("dbg_two_retires", total, 2);
            DbgHalt = 0;
            MemReady = 0;
            @(negedge Clk);
            #1;
            chk("dbg_resume_fetch", 32'(MemRead), 1);
            chk("dbg_resume_unhalted", 32'(DbgHalted), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
